rob_nway: RTL and testbench

ROB_NWAY -- requirements
Module: rob_nway

---
 rtl/rob_nway_pkg.sv | 23 ++
 rtl/rob_wb_match.sv | 29 ++
 rtl/rob_nway.sv | 177 +++++++++++++++++
 tb/tb_rob_nway.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_nway_pkg.sv
// Shared types for the reorder buffer: instruction class, entry lifecycle,
// per-entry bookkeeping and the commit FSM encoding.
package tomasula_types;

  typedef enum logic [1:0] {OP_ALU = 2'd0, OP_BR = 2'd1, OP_LD = 2'd2, OP_ST = 2'd3} rob_op_t;

  typedef enum logic [1:0] {ENT_FREE = 2'd0, ENT_ISSUED = 2'd1, ENT_DONE = 2'd2} rob_ent_state_t;

  typedef struct packed {
    rob_ent_state_t state;
    rob_op_t        op;
    logic [4:0]     rd;
    logic           mispredict;
  } rob_entry_t;

  typedef enum logic {CM_IDLE = 1'b0, CM_MEM_WAIT = 1'b1} rob_cm_state_t;

  // Width of a writeback-port index; never zero so single-port builds still elaborate.
  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rob_wb_match.sv
// Finds which writeback port targets a given tag; the lowest port index wins
// when several ports carry the same tag.
module rob_wb_match
  import tomasula_types::*;
#(
  parameter int WB_PORTS = 5,
  parameter int TAG_W    = 3,
  localparam int PORT_W  = port_w(WB_PORTS)
) (
  input  logic [WB_PORTS-1:0]            i_wb_valid,
  input  logic [WB_PORTS-1:0][TAG_W-1:0] i_wb_tag,
  input  logic [TAG_W-1:0]               i_tag,
  output logic                           o_hit,
  output logic [PORT_W-1:0]              o_port
);

  // Scan high to low so the last assignment is the lowest matching port.
  always_comb begin
    o_hit  = 1'b0;
    o_port = '0;
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (i_wb_valid[p] && (i_wb_tag[p] == i_tag)) begin
        o_hit  = 1'b1;
        o_port = PORT_W'(p);
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// Reorder buffer with N writeback ports, two operand lookups and an in-order
// single-retire commit FSM that sequences loads/stores to memory.
module rob_nway
  import tomasula_types::*;
#(
  parameter int DEPTH    = 8,
  parameter int WB_PORTS = 5,
  parameter int XLEN     = 32,
  localparam int TAG_W   = $clog2(DEPTH),
  localparam int CNT_W   = TAG_W + 1,
  localparam int PORT_W  = port_w(WB_PORTS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_alloc_valid,
  input  rob_op_t                        i_alloc_op,
  input  logic [4:0]                     i_alloc_rd,
  output logic                           o_alloc_ready,
  output logic [TAG_W-1:0]               o_alloc_tag,
  input  logic [WB_PORTS-1:0]            i_wb_valid,
  input  logic [WB_PORTS-1:0][TAG_W-1:0] i_wb_tag,
  input  logic [WB_PORTS-1:0][XLEN-1:0]  i_wb_data,
  input  logic [WB_PORTS-1:0]            i_wb_mispredict,
  input  logic [1:0][TAG_W-1:0]          i_rd_tag,
  output logic [1:0]                     o_rd_ready,
  output logic [1:0][XLEN-1:0]           o_rd_data,
  output logic                           o_commit_valid,
  output logic [4:0]                     o_commit_rd,
  output logic [XLEN-1:0]                o_commit_data,
  output logic [TAG_W-1:0]               o_commit_tag,
  output logic                           o_mem_read,
  output logic                           o_mem_write,
  output logic [XLEN-1:0]                o_mem_addr,
  input  logic                           i_mem_resp,
  input  logic [XLEN-1:0]                i_mem_rdata,
  output logic                           o_flush,
  output logic [XLEN-1:0]                o_redirect_pc,
  output logic [CNT_W-1:0]               o_count
);

  rob_entry_t    r_ent  [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [TAG_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  rob_cm_state_t r_cstate;

  logic [DEPTH-1:0]  w_ent_hit;
  logic [PORT_W-1:0] w_ent_port [DEPTH];
  logic [1:0]        w_rd_hit;
  logic [PORT_W-1:0] w_rd_port  [2];
  logic              w_alloc, w_go_mem;
  rob_entry_t        w_head;
  logic [XLEN-1:0]   w_head_data;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rob_wb_match #(.WB_PORTS(WB_PORTS), .TAG_W(TAG_W)) u_match (
      .i_wb_valid (i_wb_valid),
      .i_wb_tag   (i_wb_tag),
      .i_tag      (TAG_W'(e)),
      .o_hit      (w_ent_hit[e]),
      .o_port     (w_ent_port[e])
    );
  end

  for (genvar r = 0; r < 2; r++) begin : g_rd
    rob_wb_match #(.WB_PORTS(WB_PORTS), .TAG_W(TAG_W)) u_match (
      .i_wb_valid (i_wb_valid),
      .i_wb_tag   (i_wb_tag),
      .i_tag      (i_rd_tag[r]),
      .o_hit      (w_rd_hit[r]),
      .o_port     (w_rd_port[r])
    );
  end

  assign w_head      = r_ent[r_head];
  assign w_head_data = r_data[r_head];
  assign o_alloc_tag = r_tail;
  assign o_count     = r_count;
  assign w_alloc     = i_alloc_valid && o_alloc_ready;

  // Operand lookup: stored result first, otherwise bypass a same-cycle writeback.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      o_rd_ready[r] = 1'b0;
      o_rd_data[r]  = '0;
      if (r_ent[i_rd_tag[r]].state == ENT_DONE) begin
        o_rd_ready[r] = 1'b1;
        o_rd_data[r]  = r_data[i_rd_tag[r]];
      end else if (r_ent[i_rd_tag[r]].state == ENT_ISSUED && w_rd_hit[r]) begin
        o_rd_ready[r] = 1'b1;
        o_rd_data[r]  = i_wb_data[w_rd_port[r]];
      end
    end
  end

  always_comb begin
    o_commit_valid = 1'b0;
    o_commit_rd    = '0;
    o_commit_data  = '0;
    o_commit_tag   = '0;
    o_mem_read     = 1'b0;
    o_mem_write    = 1'b0;
    o_mem_addr     = '0;
    o_flush        = 1'b0;
    o_redirect_pc  = '0;
    w_go_mem       = 1'b0;
    if (r_cstate == CM_MEM_WAIT) begin
      o_mem_read  = (w_head.op == OP_LD);
      o_mem_write = (w_head.op == OP_ST);
      o_mem_addr  = w_head_data;
      if (i_mem_resp) begin
        o_commit_valid = 1'b1;
        o_commit_tag   = r_head;
        if (w_head.op == OP_LD) begin
          o_commit_rd   = w_head.rd;
          o_commit_data = i_mem_rdata;
        end
      end
    end else if (w_head.state == ENT_DONE) begin
      case (w_head.op)
        OP_ALU: begin
          o_commit_valid = 1'b1;
          o_commit_tag   = r_head;
          o_commit_rd    = w_head.rd;
          o_commit_data  = w_head_data;
        end
        OP_BR: begin
          o_commit_valid = 1'b1;
          o_commit_tag   = r_head;
          o_flush        = w_head.mispredict;
          o_redirect_pc  = w_head.mispredict ? w_head_data : '0;
        end
        default: w_go_mem = 1'b1;
      endcase
    end
    o_alloc_ready = (r_count < CNT_W'(DEPTH)) && !o_flush;
  end

  // A mispredict flush behaves like reset for all bookkeeping state.
  always_ff @(posedge i_clk) begin
    if (!i_rst || o_flush) begin
      for (int e = 0; e < DEPTH; e++) r_ent[e] <= '{ENT_FREE, OP_ALU, 5'd0, 1'b0};
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_cstate <= CM_IDLE;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (w_ent_hit[e] && r_ent[e].state == ENT_ISSUED) begin
          r_ent[e].state      <= ENT_DONE;
          r_ent[e].mispredict <= i_wb_mispredict[w_ent_port[e]];
        end
      end
      if (o_commit_valid) begin
        r_ent[r_head].state <= ENT_FREE;
        r_head              <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_ent[r_tail] <= '{ENT_ISSUED, i_alloc_op, i_alloc_rd, 1'b0};
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(o_commit_valid);
      if (r_cstate == CM_IDLE && w_go_mem)
        r_cstate <= CM_MEM_WAIT;
      else if (r_cstate == CM_MEM_WAIT && i_mem_resp)
        r_cstate <= CM_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (i_rst && !o_flush && w_ent_hit[e] && r_ent[e].state == ENT_ISSUED)
        r_data[e] <= i_wb_data[w_ent_port[e]];
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: directed scenarios plus random traffic, all checked
// against an in-order queue model of the reorder buffer.
module tb_rob_nway;
  import tomasula_types::*;

  localparam int DEPTH = 8, WBP = 5, XLEN = 32, TAG_W = 3;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic                         alloc_valid;
  rob_op_t                      alloc_op;
  logic [4:0]                   alloc_rd;
  logic [WBP-1:0]               wb_valid;
  logic [WBP-1:0][TAG_W-1:0]    wb_tag;
  logic [WBP-1:0][XLEN-1:0]     wb_data;
  logic [WBP-1:0]               wb_mis;
  logic [1:0][TAG_W-1:0]        rd_tag;
  logic                         mem_resp;
  logic [XLEN-1:0]              mem_rdata;

  logic                         alloc_ready, commit_valid, mem_read, mem_write, flush;
  logic [TAG_W-1:0]             alloc_tag, commit_tag;
  logic [1:0]                   rd_ready;
  logic [1:0][XLEN-1:0]         rd_data;
  logic [4:0]                   commit_rd;
  logic [XLEN-1:0]              commit_data, mem_addr, redirect_pc;
  logic [TAG_W:0]               count;

  rob_nway #(.DEPTH(DEPTH), .WB_PORTS(WBP), .XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alloc_valid(alloc_valid), .i_alloc_op(alloc_op), .i_alloc_rd(alloc_rd),
    .o_alloc_ready(alloc_ready), .o_alloc_tag(alloc_tag),
    .i_wb_valid(wb_valid), .i_wb_tag(wb_tag), .i_wb_data(wb_data), .i_wb_mispredict(wb_mis),
    .i_rd_tag(rd_tag), .o_rd_ready(rd_ready), .o_rd_data(rd_data),
    .o_commit_valid(commit_valid), .o_commit_rd(commit_rd), .o_commit_data(commit_data),
    .o_commit_tag(commit_tag), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .i_mem_resp(mem_resp), .i_mem_rdata(mem_rdata),
    .o_flush(flush), .o_redirect_pc(redirect_pc), .o_count(count)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [TAG_W-1:0] tag;
    rob_op_t          op;
    logic [4:0]       rd;
    bit               done;
    logic [XLEN-1:0]  data;
    bit               mis;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail = 0;
  bit     m_mw   = 0;

  task automatic clr_in();
    alloc_valid = 0; alloc_op = OP_ALU; alloc_rd = 0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_mis = '0;
    rd_tag = '0; mem_resp = 0; mem_rdata = '0;
  endtask

  // Compare every output against the model, then advance the model past the edge.
  task automatic cyc();
    logic e_cv, e_fl, e_mr, e_mw, e_ar, go_mem, hit;
    logic [4:0] e_rd;
    logic [XLEN-1:0] e_cd, e_pc, e_ma;
    logic [TAG_W-1:0] e_ct;
    logic [1:0] e_rr;
    logic [XLEN-1:0] e_rdd [2];
    #1;
    e_cv = 0; e_fl = 0; e_mr = 0; e_mw = 0; go_mem = 0;
    e_rd = 0; e_cd = 0; e_pc = 0; e_ma = 0; e_ct = 0;
    if (mq.size() > 0) begin
      if (m_mw) begin
        e_mr = (mq[0].op == OP_LD);
        e_mw = (mq[0].op == OP_ST);
        e_ma = mq[0].data;
        if (mem_resp) begin
          e_cv = 1; e_ct = mq[0].tag;
          if (mq[0].op == OP_LD) begin e_rd = mq[0].rd; e_cd = mem_rdata; end
        end
      end else if (mq[0].done) begin
        case (mq[0].op)
          OP_ALU: begin e_cv = 1; e_ct = mq[0].tag; e_rd = mq[0].rd; e_cd = mq[0].data; end
          OP_BR:  begin e_cv = 1; e_ct = mq[0].tag; e_fl = mq[0].mis; if (mq[0].mis) e_pc = mq[0].data; end
          default: go_mem = 1;
        endcase
      end
    end
    e_ar = (mq.size() < DEPTH) && !e_fl;
    for (int r = 0; r < 2; r++) begin
      e_rr[r] = 0; e_rdd[r] = 0;
      foreach (mq[i]) begin
        if (mq[i].tag == rd_tag[r]) begin
          if (mq[i].done) begin e_rr[r] = 1; e_rdd[r] = mq[i].data; end
          else begin
            for (int p = 0; p < WBP; p++)
              if (wb_valid[p] && wb_tag[p] == rd_tag[r]) begin e_rr[r] = 1; e_rdd[r] = wb_data[p]; break; end
          end
        end
      end
    end
    chk("alloc_ready", alloc_ready, e_ar);
    chk("alloc_tag", alloc_tag, m_tail);
    chk("count", count, mq.size());
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_rd", commit_rd, e_rd);
    chk("commit_data", commit_data, e_cd);
    chk("commit_tag", commit_tag, e_ct);
    chk("flush", flush, e_fl);
    chk("redirect_pc", redirect_pc, e_pc);
    chk("mem_read", mem_read, e_mr);
    chk("mem_write", mem_write, e_mw);
    chk("mem_addr", mem_addr, e_ma);
    for (int r = 0; r < 2; r++) begin
      chk("rd_ready", rd_ready[r], e_rr[r]);
      chk("rd_data", rd_data[r], e_rdd[r]);
    end
    if (!rst || e_fl) begin
      mq.delete(); m_tail = 0; m_mw = 0;
    end else begin
      foreach (mq[i]) begin
        if (!mq[i].done) begin
          hit = 0;
          for (int p = 0; p < WBP; p++)
            if (!hit && wb_valid[p] && wb_tag[p] == mq[i].tag) begin
              hit = 1; mq[i].done = 1; mq[i].data = wb_data[p]; mq[i].mis = wb_mis[p];
            end
        end
      end
      if (e_cv) begin void'(mq.pop_front()); m_mw = 0; end
      if (go_mem) m_mw = 1;
      if (alloc_valid && e_ar) begin
        mq.push_back('{tag: TAG_W'(m_tail), op: alloc_op, rd: alloc_rd, done: 0, data: '0, mis: 0});
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0; clr_in(); cyc(); rst = 1;
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_mem", {mem_read, mem_write, flush}, 0);
  endtask

  task automatic alloc1(input rob_op_t op, input logic [4:0] rd);
    clr_in(); alloc_valid = 1; alloc_op = op; alloc_rd = rd; cyc();
  endtask

  task automatic rnd_in();
    alloc_valid = ($urandom_range(0, 99) < 60);
    alloc_op    = rob_op_t'(2'($urandom_range(0, 3)));
    alloc_rd    = 5'($urandom);
    for (int p = 0; p < WBP; p++) begin
      wb_valid[p] = ($urandom_range(0, 99) < 30);
      if (mq.size() > 0 && $urandom_range(0, 99) < 80)
        wb_tag[p] = mq[$urandom_range(0, mq.size() - 1)].tag;
      else
        wb_tag[p] = TAG_W'($urandom);
      wb_data[p] = $urandom;
      wb_mis[p]  = ($urandom_range(0, 15) == 0);
    end
    rd_tag[0] = TAG_W'($urandom); rd_tag[1] = TAG_W'($urandom);
    mem_resp  = ($urandom_range(0, 2) == 0);
    mem_rdata = $urandom;
  endtask

  int n;

  initial begin
    clr_in();
    @(negedge clk);
    do_reset();

    // Fill all eight entries; the ninth request must be refused.
    for (int i = 0; i < 8; i++) begin
      chk("fill_tag", alloc_tag, i);
      alloc1(OP_ALU, 5'(i + 1));
    end
    chk("full_count", count, 8);
    chk("full_ready", alloc_ready, 0);
    alloc1(OP_ALU, 5'd9);
    chk("full_count_after", count, 8);

    // Out-of-order writebacks retire in program order.
    clr_in(); wb_valid[0] = 1; wb_tag[0] = 2; wb_data[0] = 'h22; cyc();
    clr_in(); wb_valid[0] = 1; wb_tag[0] = 1; wb_data[0] = 'h11; cyc();
    clr_in(); wb_valid[0] = 1; wb_tag[0] = 0; wb_data[0] = 'h00; cyc();
    clr_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("order_valid", commit_valid, 1);
      chk("order_tag", commit_tag, i);
      chk("order_data", commit_data, (i == 0) ? 'h00 : (i == 1) ? 'h11 : 'h22);
      cyc();
    end

    // Load at head: three-cycle memory handshake.
    do_reset();
    alloc1(OP_LD, 5'd3);
    clr_in(); wb_valid[2] = 1; wb_tag[2] = 0; wb_data[2] = 'h1000; cyc();
    n = 0;
    for (int k = 0; k < 7; k++) begin
      clr_in(); mem_resp = (k == 3); mem_rdata = 'hCAFE;
      #1;
      if (mem_read) begin n++; chk("ld_addr", mem_addr, 'h1000); end
      if (commit_valid) chk("ld_data", commit_data, 'hCAFE);
      cyc();
    end
    chk("ld_read_cycles", n, 3);

    // Mispredicted branch squashes younger entries.
    do_reset();
    alloc1(OP_ALU, 5'd1);
    alloc1(OP_BR, 5'd0);
    for (int i = 0; i < 4; i++) alloc1(OP_ALU, 5'(i + 2));
    clr_in();
    wb_valid = 5'b00011; wb_tag[0] = 0; wb_data[0] = 5; wb_tag[1] = 1; wb_data[1] = 'h80; wb_mis[1] = 1;
    cyc();
    clr_in(); cyc();
    alloc_valid = 1; wb_valid[0] = 1; wb_tag[0] = 2; wb_data[0] = 'h77;
    #1;
    chk("br_flush", flush, 1);
    chk("br_pc", redirect_pc, 'h80);
    cyc();
    clr_in();
    chk("br_count", count, 0);
    chk("br_tag", alloc_tag, 0);
    cyc();

    // Two ports hit the same tag: port 0 wins for bypass and storage.
    do_reset();
    for (int i = 0; i < 5; i++) alloc1(OP_ALU, 5'(i + 1));
    clr_in();
    wb_valid = 5'b01001; wb_tag[0] = 4; wb_data[0] = 'hA; wb_tag[3] = 4; wb_data[3] = 'hB; rd_tag[0] = 4;
    #1;
    chk("dup_bypass_rdy", rd_ready[0], 1);
    chk("dup_bypass_data", rd_data[0], 'hA);
    cyc();
    clr_in(); rd_tag[0] = 4;
    #1;
    chk("dup_stored", rd_data[0], 'hA);
    cyc();

    // Wrap-around over 20 alloc/commit pairs.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      chk("wrap_tag", alloc_tag, i % 8);
      alloc1(OP_ALU, 5'd7);
      clr_in(); wb_valid[4] = 1; wb_tag[4] = TAG_W'(i % 8); wb_data[4] = i; cyc();
      clr_in(); cyc();
      chk("wrap_count", count <= 8, 1);
    end

    // Reset while a store waits on memory drops the request.
    alloc1(OP_ST, 5'd2);
    clr_in(); wb_valid[1] = 1; wb_tag[1] = 4; wb_data[1] = 'h40; cyc();
    clr_in(); cyc();
    #1;
    chk("st_wait_write", mem_write, 1);
    rst = 0; cyc(); rst = 1;
    #1;
    chk("st_rst_write", mem_write, 0);
    cyc();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rnd_in();
      rst = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
